// File: rtl/sniff_shift_window_if.sv
// Bundle of the sniffer byte-window signals between the front-end driver
// and the window register. The driver is the master; the window register is the slave.
interface sniff_shift_window_if #(
    parameter int DEPTH  = 12,
    parameter int DATA_W = 8,
    parameter int TAG_W  = 2
);
    localparam int FC_W = $clog2(DEPTH + 1);

    logic                      en;
    logic                      flush;
    logic [DATA_W-1:0]         data_in;
    logic [TAG_W-1:0]          tag_in;
    logic [DATA_W-1:0]         data_out;
    logic [TAG_W-1:0]          tag_out;
    logic                      valid_out;
    logic                      out_strobe;
    logic [DEPTH*DATA_W-1:0]   data_window;
    logic [DEPTH*TAG_W-1:0]    tag_window;
    logic [DEPTH-1:0]          valid_window;
    logic [FC_W-1:0]           fill_count;
    logic                      full;

    modport master (
        output en, flush, data_in, tag_in,
        input  data_out, tag_out, valid_out, out_strobe,
        input  data_window, tag_window, valid_window, fill_count, full
    );

    modport slave (
        input  en, flush, data_in, tag_in,
        output data_out, tag_out, valid_out, out_strobe,
        output data_window, tag_window, valid_window, fill_count, full
    );
endinterface

// File: rtl/sniff_shift_window.sv
// DEPTH-stage byte/tag window with per-stage valids, flush and fill tracking.
// Stage 0 holds the newest byte; the oldest byte leaves from stage DEPTH-1.
module sniff_shift_window #(
    parameter int DEPTH  = 12,
    parameter int DATA_W = 8,
    parameter int TAG_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    sniff_shift_window_if.slave bus
);
    localparam int FC_W = $clog2(DEPTH + 1);

    logic [DEPTH*DATA_W-1:0] data_win;
    logic [DEPTH*TAG_W-1:0]  tag_win;
    logic [DEPTH-1:0]        valid_win;
    logic [FC_W-1:0]         fill_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [DATA_W-1:0] data_reg;
            logic [DATA_W-1:0] data_next;
            logic [TAG_W-1:0]  tag_reg;
            logic [TAG_W-1:0]  tag_next;
            logic              valid_reg;
            logic              valid_next;

            if (gi == 0) begin : g_head
                always_comb begin
                    data_next  = bus.data_in;
                    tag_next   = bus.tag_in;
                    valid_next = 1'b1;
                end
            end else begin : g_body
                always_comb begin
                    data_next  = data_win[(gi-1)*DATA_W +: DATA_W];
                    tag_next   = tag_win[(gi-1)*TAG_W +: TAG_W];
                    valid_next = valid_win[gi-1];
                end
            end

            // Flush together with en restarts the window on the incoming byte.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg  <= '0;
                    tag_reg   <= '0;
                    valid_reg <= 1'b0;
                end else if (bus.flush) begin
                    if (gi == 0 && bus.en) begin
                        data_reg  <= data_next;
                        tag_reg   <= tag_next;
                        valid_reg <= valid_next;
                    end else begin
                        data_reg  <= '0;
                        tag_reg   <= '0;
                        valid_reg <= 1'b0;
                    end
                end else if (bus.en) begin
                    data_reg  <= data_next;
                    tag_reg   <= tag_next;
                    valid_reg <= valid_next;
                end
            end

            assign data_win[gi*DATA_W +: DATA_W] = data_reg;
            assign tag_win[gi*TAG_W +: TAG_W]    = tag_reg;
            assign valid_win[gi]                 = valid_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_reg <= '0;
        end else if (bus.flush) begin
            fill_reg <= bus.en ? FC_W'(1) : '0;
        end else if (bus.en && fill_reg != FC_W'(DEPTH)) begin
            fill_reg <= fill_reg + FC_W'(1);
        end
    end

    assign bus.data_window  = data_win;
    assign bus.tag_window   = tag_win;
    assign bus.valid_window = valid_win;
    assign bus.data_out     = data_win[(DEPTH-1)*DATA_W +: DATA_W];
    assign bus.tag_out      = tag_win[(DEPTH-1)*TAG_W +: TAG_W];
    assign bus.valid_out    = valid_win[DEPTH-1];
    assign bus.out_strobe   = bus.en & ~bus.flush & valid_win[DEPTH-1];
    assign bus.fill_count   = fill_reg;
    assign bus.full         = (fill_reg == FC_W'(DEPTH));
endmodule

// File: tb/tb_sniff_shift_window.sv
// Drives a 12x8/2 window and a 4x16/3 window with the same stimulus and
// compares both against a queue-based model of the byte window.
module tb_sniff_shift_window;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    // Model: newest byte at index 0, entry = {tag[2:0], data[15:0]}
    logic [18:0] qa[$];
    logic [18:0] qb[$];

    sniff_shift_window_if #(.DEPTH(12), .DATA_W(8),  .TAG_W(2)) ifa ();
    sniff_shift_window_if #(.DEPTH(4),  .DATA_W(16), .TAG_W(3)) ifb ();

    sniff_shift_window #(.DEPTH(12), .DATA_W(8), .TAG_W(2)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    sniff_shift_window #(.DEPTH(4), .DATA_W(16), .TAG_W(3)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [18:0] entry(input bit sel, input int i);
        logic [18:0] e;
        e = '0;
        if (sel) begin
            if (i < qb.size()) e = qb[i];
        end else begin
            if (i < qa.size()) e = qa[i];
        end
        return e;
    endfunction

    function automatic logic [127:0] exp_data_win(input bit sel);
        logic [127:0] w;
        logic [18:0]  e;
        int depth, dw;
        depth = sel ? 4 : 12;
        dw    = sel ? 16 : 8;
        w = '0;
        for (int i = 0; i < depth; i++) begin
            e = entry(sel, i);
            w = w | (128'(e[15:0]) << (i * dw));
        end
        return w;
    endfunction

    function automatic logic [127:0] exp_tag_win(input bit sel);
        logic [127:0] w;
        logic [18:0]  e;
        int depth, tw;
        depth = sel ? 4 : 12;
        tw    = sel ? 3 : 2;
        w = '0;
        for (int i = 0; i < depth; i++) begin
            e = entry(sel, i);
            w = w | (128'(e[18:16]) << (i * tw));
        end
        return w;
    endfunction

    function automatic logic [127:0] exp_valid_win(input int n);
        return (128'(1) << n) - 128'(1);
    endfunction

    task automatic check_state();
        check_value("a_data_window",  ifa.data_window,  exp_data_win(1'b0));
        check_value("a_tag_window",   ifa.tag_window,   exp_tag_win(1'b0));
        check_value("a_valid_window", ifa.valid_window, exp_valid_win(qa.size()));
        check_value("a_fill_count",   ifa.fill_count,   qa.size());
        check_value("a_full",         ifa.full,         qa.size() == 12);
        check_value("b_data_window",  ifb.data_window,  exp_data_win(1'b1));
        check_value("b_tag_window",   ifb.tag_window,   exp_tag_win(1'b1));
        check_value("b_valid_window", ifb.valid_window, exp_valid_win(qb.size()));
        check_value("b_fill_count",   ifb.fill_count,   qb.size());
        check_value("b_full",         ifb.full,         qb.size() == 4);
    endtask

    // Called just after a rising edge; covers one full clock cycle.
    task automatic step(input bit e, input bit f, input logic [15:0] d, input logic [2:0] t);
        logic [18:0] ea;
        logic [18:0] eb;
        ifa.en = e; ifa.flush = f; ifa.data_in = d[7:0]; ifa.tag_in = t[1:0];
        ifb.en = e; ifb.flush = f; ifb.data_in = d;      ifb.tag_in = t;
        @(negedge clk);
        ea = entry(1'b0, 11);
        eb = entry(1'b1, 3);
        check_value("a_out_strobe", ifa.out_strobe, e & ~f & (qa.size() == 12));
        check_value("a_data_out",   ifa.data_out,   ea[15:0]);
        check_value("a_tag_out",    ifa.tag_out,    ea[18:16]);
        check_value("a_valid_out",  ifa.valid_out,  qa.size() == 12);
        check_value("b_out_strobe", ifb.out_strobe, e & ~f & (qb.size() == 4));
        check_value("b_data_out",   ifb.data_out,   eb[15:0]);
        check_value("b_tag_out",    ifb.tag_out,    eb[18:16]);
        check_value("b_valid_out",  ifb.valid_out,  qb.size() == 4);
        @(posedge clk);
        if (f) begin
            qa.delete();
            qb.delete();
        end
        if (e) begin
            qa.push_front({1'b0, t[1:0], 8'h00, d[7:0]});
            qb.push_front({t, d});
            if (qa.size() > 12) void'(qa.pop_back());
            if (qb.size() > 4)  void'(qb.pop_back());
        end
        #1;
        check_state();
        txn++;
        $display("txn %0d en=%0b flush=%0b data=%04h tag=%0d fill_a=%0d fill_b=%0d",
                 txn, e, f, d, t, ifa.fill_count, ifb.fill_count);
    endtask

    initial begin
        rst = 1'b1;
        ifa.en = 1'b0; ifa.flush = 1'b0; ifa.data_in = '0; ifa.tag_in = '0;
        ifb.en = 1'b0; ifb.flush = 1'b0; ifb.data_in = '0; ifb.tag_in = '0;
        #2;
        check_state();
        check_value("a_reset_strobe", ifa.out_strobe, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill from empty, then one eviction
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 16'h0030 + 16'(i), 3'b001);
        step(1'b1, 1'b0, 16'h0020, 3'b010);

        // Empty, then five bytes interleaved with idle cycles
        step(1'b0, 1'b1, 16'h0000, 3'b000);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 16'($urandom), 3'($urandom));
            step(1'b0, 1'b0, 16'($urandom), 3'($urandom));
            step(1'b0, 1'b0, 16'($urandom), 3'($urandom));
        end

        // Two more shifts to reach seven, then flush with and without en
        step(1'b1, 1'b0, 16'h0041, 3'b001);
        step(1'b1, 1'b0, 16'h0042, 3'b001);
        step(1'b1, 1'b1, 16'h002C, 3'b010);
        step(1'b0, 1'b1, 16'h00FF, 3'b111);

        // Asynchronous reset between edges with both windows full
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 16'($urandom), 3'($urandom));
        ifa.en = 1'b0; ifb.en = 1'b0;
        #3;
        rst = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        check_state();
        check_value("a_valid_out_rst", ifa.valid_out, 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 16'h1234, 3'b101);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 16'($urandom), 3'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sniff_shift_window.md
Name: sniff_shift_window

Overview:
- Parametrised byte-window shift register for the sniffer datapath.
- Carries each received byte plus its classifier tags (bit0 = is_number, bit1 = is_white) through DEPTH stages.
- Exposes the whole window in parallel to the pattern matchers.
- Adds behaviour the fixed 12-stage chain lacks: async reset, per-stage valid tracking, synchronous flush, fill counter and an eviction strobe, so matchers never act on stale or empty stages.

Parameters:
- DEPTH, 12, number of stages; legal range 2..64.
- DATA_W, 8, data bits per stage.
- TAG_W, 2, tag bits per stage; bit0 = is_number, bit1 = is_white, further bits are user-defined.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  shift strobe; one new byte accepted per cycle with en=1.
- flush  in  1  synchronous clear of window contents and valids.
- data_in  in  DATA_W  byte entering stage 0.
- tag_in  in  TAG_W  tags of data_in.
- data_out  out  DATA_W  stage DEPTH-1 data.
- tag_out  out  TAG_W  stage DEPTH-1 tags.
- valid_out  out  1  stage DEPTH-1 valid.
- out_strobe  out  1  combinational; =en & ~flush & valid_out; data_out/tag_out are the byte being evicted this cycle.
- data_window  out  DEPTH*DATA_W  all stages; slice i = stage i, stage 0 = newest, in bits [i*DATA_W +: DATA_W].
- tag_window  out  DEPTH*TAG_W  all stage tags, same ordering.
- valid_window  out  DEPTH  per-stage valid bits.
- fill_count  out  $clog2(DEPTH+1)  number of valid stages.
- full  out  1  fill_count == DEPTH.

Behaviour:
- Reset (rst=1, async): every stage data=0, tags=0, valid=0; fill_count=0; full=0; out_strobe=0 (valid_out=0). Reset mid-stream discards all contents immediately, without waiting for a clock edge.
- Idle (en=0, flush=0): all registers hold; out_strobe=0.
- Shift (en=1, flush=0), at the rising edge:
  - stage0 <= {data_in, tag_in, valid=1};
  - stage i <= stage i-1, for i = 1..DEPTH-1;
  - previous stage DEPTH-1 is discarded; out_strobe was high during that cycle if it was valid.
- Valids are contiguous from stage 0: valid_window is always of the form 0..01..1, with the 1s starting at stage 0.
- fill_count on shift: increments by 1 while < DEPTH; saturates at DEPTH (new byte in, oldest out).
- Latency: a byte entered on shift k appears on data_out after shift k+DEPTH-1 and is evicted, with out_strobe=1, on shift k+DEPTH. Latency counts en pulses, not clocks.
- Flush only (flush=1, en=0): all valids cleared; data/tags cleared to 0; fill_count=0; full=0.
- Flush and shift together (flush=1, en=1): flush wins for the old contents. Stage0 loads data_in/tag_in with valid=1; all other stages are cleared; fill_count=1. out_strobe=0, so no eviction is reported for discarded bytes. This restarts a window on a delimiter byte with no lost cycle.
- full: combinational from fill_count; no extra register.
- Width rules:
  - fill_count width is $clog2(DEPTH+1); DEPTH=12 gives 4 bits.
  - No arithmetic on data/tags; they pass through unchanged.
- Window outputs come directly from stage registers: no combinational path from data_in/tag_in to any output. out_strobe is the only output combinational in en/flush.

Test Plan:
- Reset then 12 shifts of bytes 0x30..0x3B, tags 2'b01 (DEPTH=12) -> fill_count steps 1..12; full=1 after 12th edge; data_window stage0=0x3B, stage11=0x30; valid_window=12'hFFF; out_strobe never high.
- Continue with a 13th shift, byte 0x20 tag 2'b10 -> out_strobe=1 during that cycle with data_out=0x30; afterwards stage0=0x20/tag 2'b10, data_out=0x31, fill_count stays 12.
- Interleave en with idle cycles (en=1,0,0,1,...) for 5 bytes -> contents change only on en edges; fill_count=5; valid_window=12'h01F.
- After 7 shifts, assert flush with en=1 and data_in=0x2C -> next edge: stage0=0x2C valid, all other stages 0/invalid; fill_count=1; out_strobe=0 on that cycle. Repeat with flush, en=0 -> fill_count=0 and all valids 0.
- Assert rst asynchronously, between edges, with the window full -> outputs go to 0 before the next clock; first shift after release gives fill_count=1.
- Re-run the first three scenarios with DEPTH=4, DATA_W=16, TAG_W=3 -> same properties: fill_count width 3, full at 4, 4-shift eviction latency.
